// File: rtl/ov7670_capture_if.sv
// ov7670_capture_if
//   Bundles the camera-side inputs, the arming level and the frame-buffer
//   write side of the OV7670 pixel capture stage.
//   master : the capture block (samples camera/config, drives writes/status)
//   slave  : the surrounding system (drives camera/config, consumes writes)
//   Signals:
//     config_done         arming level from the SCCB controller
//     cam_pclk/vsync/href camera timing, asynchronous to clk
//     cam_d[7:0]          camera data byte
//     wr_en/addr/data     one write per RGB565 pixel
//     frame_done          one-cycle end-of-frame pulse
//     frame_cnt[7:0]      completed frames, wrapping
//     line_err            sticky bad-line-length flag
interface ov7670_capture_if #(
   parameter int ADDR_W = 15
);
   logic              config_done;
   logic              cam_pclk;
   logic              cam_vsync;
   logic              cam_href;
   logic [7:0]        cam_d;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [15:0]       wr_data;
   logic              frame_done;
   logic [7:0]        frame_cnt;
   logic              line_err;

   modport master (
      input  config_done, cam_pclk, cam_vsync, cam_href, cam_d,
      output wr_en, wr_addr, wr_data, frame_done, frame_cnt, line_err
   );

   modport slave (
      output config_done, cam_pclk, cam_vsync, cam_href, cam_d,
      input  wr_en, wr_addr, wr_data, frame_done, frame_cnt, line_err
   );
endinterface

// File: rtl/ov7670_capture.sv
// ov7670_capture
//   Samples the OV7670 parallel bus in the clk domain once armed by
//   config_done, pairs bytes into RGB565 pixels and issues one write per
//   pixel with a linear address. Reports frame completion and bad lines.
//   Ports:
//     clk      system clock (only clock in the block)
//     reset_n  asynchronous active-low reset
//     bus      ov7670_capture_if.master (camera in, writes/status out)
module ov7670_capture #(
   parameter int H_PIXELS = 160,
   parameter int V_LINES  = 120,
   parameter int ADDR_W   = 15
) (
   input  logic             clk,
   input  logic             reset_n,
   ov7670_capture_if.master bus
);
   localparam int XW = $clog2(H_PIXELS + 1);
   localparam int YW = $clog2(V_LINES + 1);

   typedef enum logic [1:0] {WAIT_CFG, WAIT_FRAME, CAPTURE} state_t;

   state_t r_state, w_next;

   // 2-FF synchronizers; data uses the same depth as pclk so a byte and
   // the pclk edge that qualifies it arrive together.
   logic [1:0]      r_pclk_sync, r_vs_sync, r_href_sync;
   logic [1:0][7:0] r_d_sync;
   logic            r_pclk_d, r_vs_d;

   logic            w_pclk_rise, w_vs_rise, w_vs_fall, w_href_s, w_cap;
   logic [7:0]      w_d_s;

   logic [XW-1:0]     r_x;
   logic [YW-1:0]     r_y;
   logic              r_phase, r_href_q, r_x_ovf;
   logic [7:0]        r_hi;
   logic [ADDR_W-1:0] r_addr;

   logic              r_wr_en, r_frame_done, r_line_err;
   logic [ADDR_W-1:0] r_wr_addr;
   logic [15:0]       r_wr_data;
   logic [7:0]        r_frame_cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pclk_sync <= '0;
         r_vs_sync   <= '0;
         r_href_sync <= '0;
         r_d_sync    <= '0;
         r_pclk_d    <= 1'b0;
         r_vs_d      <= 1'b0;
      end else begin
         r_pclk_sync <= {r_pclk_sync[0], bus.cam_pclk};
         r_vs_sync   <= {r_vs_sync[0], bus.cam_vsync};
         r_href_sync <= {r_href_sync[0], bus.cam_href};
         r_d_sync    <= {r_d_sync[0], bus.cam_d};
         r_pclk_d    <= r_pclk_sync[1];
         r_vs_d      <= r_vs_sync[1];
      end
   end

   assign w_pclk_rise = r_pclk_sync[1] & ~r_pclk_d;
   assign w_vs_rise   = r_vs_sync[1] & ~r_vs_d;
   assign w_vs_fall   = ~r_vs_sync[1] & r_vs_d;
   assign w_href_s    = r_href_sync[1];
   assign w_d_s       = r_d_sync[1];
   // Dropping config_done kills capture in the same cycle, not one later.
   assign w_cap       = (r_state == CAPTURE) && bus.config_done;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= WAIT_CFG;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         WAIT_CFG:   if (bus.config_done) w_next = WAIT_FRAME;
         WAIT_FRAME: if (w_vs_fall)       w_next = CAPTURE;
         CAPTURE:    if (w_vs_rise)       w_next = WAIT_FRAME;
         default:                         w_next = WAIT_CFG;
      endcase
      if (!bus.config_done) w_next = WAIT_CFG;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_x          <= '0;
         r_y          <= '0;
         r_phase      <= 1'b0;
         r_href_q     <= 1'b0;
         r_x_ovf      <= 1'b0;
         r_hi         <= '0;
         r_addr       <= '0;
         r_wr_en      <= 1'b0;
         r_wr_addr    <= '0;
         r_wr_data    <= '0;
         r_frame_done <= 1'b0;
         r_frame_cnt  <= '0;
         r_line_err   <= 1'b0;
      end else begin
         r_wr_en      <= 1'b0;
         r_frame_done <= 1'b0;
         if (!w_cap) begin
            // Outside capture the frame position is held at the origin so a
            // new frame always starts at address 0.
            r_x      <= '0;
            r_y      <= '0;
            r_phase  <= 1'b0;
            r_href_q <= 1'b0;
            r_x_ovf  <= 1'b0;
            r_addr   <= '0;
         end else begin
            if (w_pclk_rise) begin
               r_href_q <= w_href_s;
               if (w_href_s) begin
                  r_phase <= ~r_phase;
                  if (!r_phase) begin
                     r_hi <= w_d_s;
                  end else begin
                     if (r_x < XW'(H_PIXELS) && r_y < YW'(V_LINES)) begin
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= r_addr;
                        r_wr_data <= {r_hi, w_d_s};
                        r_addr    <= r_addr + 1'b1;
                     end
                     // x saturates; the overflow flag remembers an overlong
                     // line that saturation would otherwise hide.
                     if (r_x < XW'(H_PIXELS)) r_x <= r_x + 1'b1;
                     else                     r_x_ovf <= 1'b1;
                  end
               end else if (r_href_q) begin
                  if (r_phase || r_x != XW'(H_PIXELS) || r_x_ovf)
                     r_line_err <= 1'b1;
                  r_x     <= '0;
                  r_x_ovf <= 1'b0;
                  r_phase <= 1'b0;
                  if (r_y < YW'(V_LINES)) r_y <= r_y + 1'b1;
               end
            end
            // Line end above and frame end here share a cycle cleanly: the
            // line check lands first, then the state leaves CAPTURE.
            if (w_vs_rise) begin
               r_frame_done <= 1'b1;
               r_frame_cnt  <= r_frame_cnt + 8'd1;
            end
         end
      end
   end

   assign bus.wr_en      = r_wr_en;
   assign bus.wr_addr    = r_wr_addr;
   assign bus.wr_data    = r_wr_data;
   assign bus.frame_done = r_frame_done;
   assign bus.frame_cnt  = r_frame_cnt;
   assign bus.line_err   = r_line_err;
endmodule

// File: tb/tb_ov7670_capture.sv
// tb_ov7670_capture
//   Drives a small camera frame format (H x V) with random data and
//   compares every pixel write against an expected queue built from
//   the line/pixel geometry of each frame sent.
module tb_ov7670_capture;
   localparam int H  = 4;
   localparam int V  = 3;
   localparam int AW = 4;

   typedef struct packed {
      logic [AW-1:0] a;
      logic [15:0]   d;
   } wr_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;

   ov7670_capture_if #(.ADDR_W(AW)) bus ();

   ov7670_capture #(.H_PIXELS(H), .V_LINES(V), .ADDR_W(AW)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   wr_t         exp_q[$];
   logic [AW-1:0] log_addr[$];
   logic [15:0]   log_data[$];
   int          n_chk = 0;
   int          n_fail = 0;
   int          exp_frames = 0;
   int          exp_pulses = 0;
   logic        exp_err = 1'b0;
   int          done_pulses = 0;
   logic        prev_wr = 1'b0;
   int          lens[0:15];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   // Compare process: every write must match the head of the expected queue.
   always @(negedge clk) begin
      if (bus.wr_en === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_write", 64'(bus.wr_addr), 64'hFFFF);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            check("wr_addr", 64'(bus.wr_addr), 64'(e.a));
            check("wr_data", 64'(bus.wr_data), 64'(e.d));
         end
         check("wr_en_one_cycle", 64'(prev_wr), 64'(0));
         log_addr.push_back(bus.wr_addr);
         log_data.push_back(bus.wr_data);
      end
      prev_wr = (bus.wr_en === 1'b1);
      if (bus.frame_done === 1'b1) done_pulses++;
   end

   task automatic pclk_cycle(input logic h, input logic [7:0] b);
      bus.cam_href = h;
      bus.cam_d    = b;
      #40 bus.cam_pclk = 1'b1;
      #40 bus.cam_pclk = 1'b0;
   endtask

   task automatic set_lens(input int nb);
      for (int i = 0; i < 16; i++) lens[i] = nb;
   endtask

   task automatic send_line(input int nb, input bit cap, input int y, input bit fixed);
      logic [7:0] b, hi;
      hi = 8'h00;
      for (int i = 0; i < nb; i++) begin
         b = fixed ? (((i % 2) == 0) ? 8'hF8 : 8'h1F) : 8'($urandom);
         if ((i % 2) == 0) hi = b;
         else if (cap && y < V && (i / 2) < H)
            exp_q.push_back({AW'(y * H + i / 2), hi, b});
         pclk_cycle(1'b1, b);
      end
      if (cap && (((nb % 2) != 0) || (nb / 2) != H)) exp_err = 1'b1;
      pclk_cycle(1'b0, 8'($urandom));
   endtask

   task automatic send_frame(input int nl, input bit fixed, input int abort_at);
      bit cap;
      bus.cam_vsync = 1'b1;
      pclk_cycle(1'b0, 8'h00);
      bus.cam_vsync = 1'b0;
      cap = bus.config_done;
      pclk_cycle(1'b0, 8'h00);
      for (int y = 0; y < nl; y++) begin
         if (y == abort_at) begin
            bus.config_done = 1'b0;
            cap = 1'b0;
         end
         send_line(lens[y], cap, y, fixed);
      end
      bus.cam_vsync = 1'b1;
      pclk_cycle(1'b0, 8'h00);
      if (cap) begin
         exp_frames++;
         exp_pulses++;
      end
   endtask

   task automatic checkpoint(input string tag);
      check({tag, "_drained"},   64'(exp_q.size()), 64'(0));
      check({tag, "_frame_cnt"}, 64'(bus.frame_cnt), 64'(exp_frames % 256));
      check({tag, "_line_err"},  64'(bus.line_err), 64'(exp_err));
      check({tag, "_pulses"},    64'(done_pulses), 64'(exp_pulses));
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_wr_en"},      64'(bus.wr_en), 64'(0));
      check({tag, "_wr_addr"},    64'(bus.wr_addr), 64'(0));
      check({tag, "_wr_data"},    64'(bus.wr_data), 64'(0));
      check({tag, "_frame_done"}, 64'(bus.frame_done), 64'(0));
      check({tag, "_frame_cnt"},  64'(bus.frame_cnt), 64'(0));
      check({tag, "_line_err"},   64'(bus.line_err), 64'(0));
   endtask

   initial begin
      #3ms;
      n_chk++;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      int idx, base, mx;
      logic [7:0] b0, b1;
      bus.config_done = 1'b0;
      bus.cam_vsync   = 1'b1;
      bus.cam_href    = 1'b0;
      bus.cam_d       = 8'h00;
      bus.cam_pclk    = 1'b0;

      // Reset with the camera toggling.
      repeat (3) pclk_cycle(1'b1, 8'($urandom));
      check_zero("reset");
      reset_n = 1'b1;
      pclk_cycle(1'b0, 8'h00);

      // Not armed: a whole frame must produce nothing.
      set_lens(2 * H);
      send_frame(V, 1'b0, -1);
      checkpoint("unarmed");
      check("unarmed_cnt_lit", 64'(bus.frame_cnt), 64'(0));

      // Arm, then a full frame of 0xF8,0x1F.
      bus.config_done = 1'b1;
      pclk_cycle(1'b0, 8'h00);
      idx = log_addr.size();
      send_frame(V, 1'b1, -1);
      checkpoint("full");
      check("full_cnt_lit", 64'(bus.frame_cnt), 64'(1));
      check("full_err_lit", 64'(bus.line_err), 64'(0));
      check("full_nwr_lit", 64'(log_addr.size() - idx), 64'(12));
      check("full_first_data_lit", 64'(log_data[idx]), 64'h0000_0000_0000_F81F);
      check("full_first_addr_lit", 64'(log_addr[idx]), 64'(0));
      check("full_last_addr_lit", 64'(log_addr[log_addr.size() - 1]), 64'(11));

      // Random-data frames.
      repeat (3) send_frame(V, 1'b0, -1);
      checkpoint("rand");

      // Odd byte count on line 1.
      set_lens(2 * H);
      lens[1] = 2 * H + 1;
      idx = log_addr.size();
      send_frame(V, 1'b0, -1);
      checkpoint("odd");
      check("odd_err_lit", 64'(bus.line_err), 64'(1));
      check("odd_line2_addr_lit", 64'(log_addr[idx + 2 * H]), 64'(8));

      // Reset in the middle of a line: outputs clear at once, no partial write.
      bus.cam_vsync = 1'b1;
      pclk_cycle(1'b0, 8'h00);
      bus.cam_vsync = 1'b0;
      pclk_cycle(1'b0, 8'h00);
      b0 = 8'($urandom);
      b1 = 8'($urandom);
      exp_q.push_back({AW'(0), b0, b1});
      pclk_cycle(1'b1, b0);
      pclk_cycle(1'b1, b1);
      pclk_cycle(1'b1, 8'($urandom));
      reset_n = 1'b0;
      #1;
      check_zero("midreset");
      #39;
      exp_frames = 0;
      exp_err = 1'b0;
      pclk_cycle(1'b1, 8'($urandom));
      pclk_cycle(1'b0, 8'h00);
      bus.cam_vsync = 1'b1;
      pclk_cycle(1'b0, 8'h00);
      reset_n = 1'b1;
      pclk_cycle(1'b0, 8'h00);
      checkpoint("midreset");

      // Overlong lines and extra lines.
      set_lens(2 * (H + 2));
      idx = log_addr.size();
      send_frame(V + 2, 1'b0, -1);
      checkpoint("overlong");
      mx = 0;
      for (int i = idx; i < log_addr.size(); i++)
         if (int'(log_addr[i]) > mx) mx = int'(log_addr[i]);
      check("overlong_max_addr_lit", 64'(mx), 64'(11));
      check("overlong_nwr_lit", 64'(log_addr.size() - idx), 64'(12));
      check("overlong_err_lit", 64'(bus.line_err), 64'(1));

      // Abort at line 1, then re-arm.
      set_lens(2 * H);
      idx = log_addr.size();
      base = done_pulses;
      send_frame(V, 1'b0, 1);
      checkpoint("abort");
      check("abort_nwr_lit", 64'(log_addr.size() - idx), 64'(4));
      check("abort_no_done", 64'(done_pulses - base), 64'(0));
      bus.config_done = 1'b1;
      pclk_cycle(1'b0, 8'h00);
      idx = log_addr.size();
      send_frame(V, 1'b0, -1);
      checkpoint("rearm");
      check("rearm_first_addr_lit", 64'(log_addr[idx]), 64'(0));

      // 256 short frames: frame_cnt comes back to where it started.
      set_lens(2 * H);
      base = done_pulses;
      repeat (256) send_frame(2, 1'b0, -1);
      checkpoint("wrap");
      check("wrap_pulses_lit", 64'(done_pulses - base), 64'(256));
      check("wrap_cnt_lit", 64'(bus.frame_cnt), 64'(2));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
